muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the multicycle MIPS core; implements MULT, MULTU, DIV and DIVU into the HI/LO register pair.
- The main control unit pulses start, then holds the instruction stream in a wait state while busy=1.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle, plus a sign-fix cycle.
- Owns HI/LO, so also services MTHI/MTLO writes and feeds MFHI/MFLO reads.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH split across HI and LO; latency scales as WIDTH+2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE or DONE.
- op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV; sampled with start.
- a  input  WIDTH  rs operand (multiplicand or dividend); latched at start.
- b  input  WIDTH  rt operand (multiplier or divisor); latched at start.
- mthi  input  1  write wdata into HI.
- mtlo  input  1  write wdata into LO.
- wdata  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  operation in progress; control unit must stall.
- done  output  1  one-cycle pulse when HI/LO hold a new result.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (reset=0 at an edge), from any state including mid-operation:
  - state=IDLE, busy=0, done=0, hi=0, lo=0.
  - Iteration counter and internal accumulators cleared.
  - Any in-flight result is discarded.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: latch op, a and b.
  - For signed ops, convert the operands to magnitudes and record the result signs.
  - Counter=0; go to CALC.
- CALC:
  - busy=1; exactly WIDTH cycles; one bit per cycle; counter increments each cycle.
  - Leave to SIGN when counter==WIDTH-1.
- SIGN:
  - busy=1; one cycle; apply the sign fix.
  - hi/lo are written at the edge leaving SIGN; go to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back ops); otherwise go to IDLE.
- Latency: start sampled at edge N, then:
  - busy=1 from edge N+1 to edge N+WIDTH+2 (WIDTH+1 cycles);
  - hi/lo updated at edge N+WIDTH+2;
  - done high for the following cycle.
- start while busy=1 is ignored: no restart, no queuing.
- Operands changing after the start edge have no effect on the result.
- Multiply:
  - {hi,lo} = a*b, full 2*WIDTH product.
  - MULT (signed): the product is negated when the operand signs differ.
- Divide, normal case: lo = quotient, hi = remainder.
- Divide, signed (DIV):
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - -2^(WIDTH-1) / -1 yields lo=0x80000000, hi=0 (no trap).
- Divide by zero (DIVU or DIV):
  - lo=all ones, hi=a unmodified.
  - Same latency; no error flag.
- MTHI/MTLO:
  - Honoured in IDLE and DONE only; they write hi/lo at the edge.
  - In DONE they override the value just produced.
  - Ignored while busy=1.
  - mthi and mtlo together write both registers.
  - Same-edge start plus mthi/mtlo: the register write applies now; the later result overwrites it.
- hi/lo hold their value at all other times; reads are always valid outside the SIGN-edge update.

Test Plan:
- Unsigned multiply: MULTU a=0xFFFFFFFF, b=2 -> after WIDTH+2 edges, hi=0x00000001, lo=0xFFFFFFFE, done pulses exactly once, busy high for 33 cycles.
- Signed multiply then divide: MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Back-to-back DIV issued in the DONE cycle with a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Edge divides:
  - DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Busy protection: DIVU 1000/7 started, then start and mthi (wdata=0x1234) pulsed at cycle 5 -> both ignored; final lo=142, hi=6.
- Reset mid-operation: reset=0 at cycle 10 of MULTU -> next cycle busy=0, done=0, hi=lo=0. A new MULTU 6*7 afterwards -> lo=42, hi=0.
- Register writes: MTLO wdata=0xCAFEBABE in IDLE -> lo=0xCAFEBABE next cycle, hi unchanged. Operands driven to X after the start edge -> result unaffected.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Handshake and data bundle between the main control unit and the HI/LO
// multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: radix-2 shift-add multiply,
// restoring divide on magnitudes, then a single sign-fix cycle.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              dz_q, dz_d;
  logic [WIDTH-1:0]  a_raw_q, a_raw_d;
  logic [WIDTH-1:0]  m_q, m_d;
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign a_neg = bus.op[0] & bus.a[WIDTH-1];
  assign b_neg = bus.op[0] & bus.b[WIDTH-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  // Multiply: acc_lo holds the multiplier, shifted out LSB-first as product bits shift in.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, m_q};
  assign div_sub   = div_shift[WIDTH-1:0] - m_q;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = rem_neg_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    a_raw_d   = a_raw_q;
    m_d       = m_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.mthi) hi_d = bus.wdata;
        if (bus.mtlo) lo_d = bus.wdata;
        state_d = StIdle;
        if (bus.start) begin
          is_div_d  = bus.op[1];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          dz_d      = bus.op[1] && (bus.b == '0);
          a_raw_d   = bus.a;
          acc_hi_d  = '0;
          acc_lo_d  = bus.op[1] ? a_mag : b_mag;
          m_d       = bus.op[1] ? b_mag : a_mag;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CntLast) state_d = StSign;
      end
      StSign: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_q) begin
          // Divide by zero bypasses the sign fix: HI gets the raw dividend.
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      a_raw_q   <= '0;
      m_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      a_raw_q   <= a_raw_d;
      m_q       <= m_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
